// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types.
// Word type and RAM status encoding.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;
endpackage

// File: rtl/ram_arbiter_pkg.sv
// RAM arbiter types.
// FSM states and granted request kinds.
package ram_arbiter_pkg;
  typedef enum logic {
    IDLE,
    XFER
  } arb_state_t;
  typedef enum logic [1:0] {
    IRD,
    DRD,
    DWR
  } req_type_t;
endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// Round-robin priority encoder.
// First requester at or after ptr, wrapping modulo CPUS.
module rr_picker #(
  parameter int CPUS = 2,
  parameter int IW   = 1
) (
  input  logic [CPUS-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);
  always_comb begin
    valid = |req;
    idx   = '0;
    // scan farthest first so the nearest hit wins
    for (int k = CPUS - 1; k >= 0; k--) begin
      int c;
      c = (int'(ptr) + k) % CPUS;
      if (req[c]) idx = IW'(c);
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// Shares one variable-latency RAM port between
// the instruction and data requests of CPUS cores.
module ram_arbiter
  import cpu_types_pkg::*;
  import ram_arbiter_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CPUS-1:0]     iREN,
  input  logic [CPUS-1:0]     dREN,
  input  logic [CPUS-1:0]     dWEN,
  input  word_t [CPUS-1:0]    iaddr,
  input  word_t [CPUS-1:0]    daddr,
  input  word_t [CPUS-1:0]    dstore,
  output logic [CPUS-1:0]     iwait,
  output logic [CPUS-1:0]     dwait,
  output word_t [CPUS-1:0]    iload,
  output word_t [CPUS-1:0]    dload,
  input  ramstate_t           ramstate,
  input  word_t               ramload,
  output word_t               ramaddr,
  output word_t               ramstore,
  output logic                ramREN,
  output logic                ramWEN
);
  localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;

  arb_state_t    state, state_n;
  logic [IW-1:0] rr_ptr, rr_next;
  logic [IW-1:0] gnt_cpu, pick;
  req_type_t     gnt_type, pick_type;
  logic          pick_valid, live, done;
  logic [CPUS-1:0] any_req;

  assign any_req = iREN | dREN | dWEN;

  rr_picker #(.CPUS(CPUS), .IW(IW)) u_pick (
    .req  (any_req),
    .ptr  (rr_ptr),
    .valid(pick_valid),
    .idx  (pick)
  );

  always_comb begin
    pick_type = IRD;
    priority case (1'b1)
      dWEN[pick]: pick_type = DWR;
      dREN[pick]: pick_type = DRD;
      default:    pick_type = IRD;
    endcase
  end

  assign rr_next = (gnt_cpu == IW'(CPUS - 1))
                 ? '0 : gnt_cpu + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt_cpu  <= '0;
      gnt_type <= IRD;
    end else begin
      state <= state_n;
      if (state == IDLE && pick_valid) begin
        gnt_cpu  <= pick;
        gnt_type <= pick_type;
      end
      if (done) rr_ptr <= rr_next;
    end
  end

  always_comb begin
    state_n  = state;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    live     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: if (pick_valid) state_n = XFER;
      XFER: begin
        unique case (gnt_type)
          DWR:     live = dWEN[gnt_cpu];
          DRD:     live = dREN[gnt_cpu];
          default: live = iREN[gnt_cpu];
        endcase
        // a dropped request abandons the grant untouched
        if (!live) begin
          state_n = IDLE;
        end else begin
          done = (ramstate == ACCESS);
          if (done) state_n = IDLE;
          unique case (gnt_type)
            DWR: begin
              ramWEN          = 1'b1;
              ramaddr         = daddr[gnt_cpu];
              ramstore        = dstore[gnt_cpu];
              dwait[gnt_cpu]  = !done;
            end
            DRD: begin
              ramREN          = 1'b1;
              ramaddr         = daddr[gnt_cpu];
              dwait[gnt_cpu]  = !done;
              if (done) dload[gnt_cpu] = ramload;
            end
            default: begin
              ramREN          = 1'b1;
              ramaddr         = iaddr[gnt_cpu];
              iwait[gnt_cpu]  = !done;
              if (done) iload[gnt_cpu] = ramload;
            end
          endcase
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed plan steps plus
// random traffic against a transaction-level model.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;

  logic              CLK = 1'b0;
  logic              RST;
  logic [CPUS-1:0]   iREN, dREN, dWEN;
  word_t [CPUS-1:0]  iaddr, daddr, dstore;
  logic [CPUS-1:0]   iwait, dwait;
  word_t [CPUS-1:0]  iload, dload;
  ramstate_t         ramstate;
  word_t             ramload, ramaddr, ramstore;
  logic              ramREN, ramWEN;

  ram_arbiter #(.CPUS(CPUS)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload),
    .ramstate(ramstate), .ramload(ramload),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramREN(ramREN), .ramWEN(ramWEN)
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;

  // model: one open transaction (core, kind 0=ifetch 1=read 2=write)
  bit m_ok   = 0;
  bit m_busy = 0;
  int m_cpu  = 0;
  int m_kind = 0;
  int m_ptr  = 0;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic bit m_live();
    case (m_kind)
      0:       return iREN[m_cpu];
      1:       return dREN[m_cpu];
      default: return dWEN[m_cpu];
    endcase
  endfunction

  task automatic settle();
    logic [CPUS-1:0]  e_iw, e_dw;
    word_t [CPUS-1:0] e_il, e_dl;
    logic             e_ren, e_wen;
    word_t            e_addr, e_st;
    bit               acc;
    @(negedge CLK);
    if (m_ok) begin
      e_iw = '1; e_dw = '1; e_il = '0; e_dl = '0;
      e_ren = 0; e_wen = 0; e_addr = '0; e_st = '0;
      if (m_busy && m_live()) begin
        acc = (ramstate == ACCESS);
        case (m_kind)
          0: begin
            e_ren = 1; e_addr = iaddr[m_cpu];
            e_iw[m_cpu] = !acc;
            if (acc) e_il[m_cpu] = ramload;
          end
          1: begin
            e_ren = 1; e_addr = daddr[m_cpu];
            e_dw[m_cpu] = !acc;
            if (acc) e_dl[m_cpu] = ramload;
          end
          default: begin
            e_wen = 1; e_addr = daddr[m_cpu];
            e_st = dstore[m_cpu];
            e_dw[m_cpu] = !acc;
          end
        endcase
      end
      chk("m_iwait", iwait, e_iw);
      chk("m_dwait", dwait, e_dw);
      chk("m_iload", iload, e_il);
      chk("m_dload", dload, e_dl);
      chk("m_ren", ramREN, e_ren);
      chk("m_wen", ramWEN, e_wen);
      chk("m_addr", ramaddr, e_addr);
      chk("m_store", ramstore, e_st);
      chk("excl", ramREN & ramWEN, 0);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST) begin
      m_busy = 0; m_ptr = 0; m_ok = 1;
    end else if (!m_busy) begin
      for (int k = 0; k < CPUS; k++) begin
        int c;
        c = (m_ptr + k) % CPUS;
        if (!m_busy && (iREN[c] | dREN[c] | dWEN[c])) begin
          m_busy = 1; m_cpu = c;
          m_kind = dWEN[c] ? 2 : (dREN[c] ? 1 : 0);
        end
      end
    end else if (!m_live()) begin
      m_busy = 0;
    end else if (ramstate == ACCESS) begin
      m_busy = 0;
      m_ptr = (m_cpu + 1) % CPUS;
    end
    #1;
  endtask

  task automatic quiet();
    iREN = '0; dREN = '0; dWEN = '0;
  endtask

  logic [1:0] rr_exp [8];

  initial begin
    RST = 1; iREN = '1; dREN = '1; dWEN = '1;
    iaddr = '0; daddr = '0; dstore = '0;
    ramstate = FREE; ramload = '0;
    // reset with all requests high
    tick(); settle(); tick(); settle();
    chk("rst_iwait", iwait, 2'b11);
    chk("rst_dwait", dwait, 2'b11);
    chk("rst_ren", ramREN, 0);
    chk("rst_wen", ramWEN, 0);
    chk("rst_addr", ramaddr, 0);
    RST = 0; quiet(); tick();

    // single core instruction read
    iREN = 2'b01; iaddr[0] = 32'h40; ramstate = BUSY;
    settle(); chk("rd_idle_ren", ramREN, 0); tick();
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("rd_busy_ren", ramREN, 1);
      chk("rd_busy_addr", ramaddr, 32'h40);
      chk("rd_busy_iwait", iwait, 2'b11);
      tick();
    end
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    settle();
    chk("rd_acc_iwait", iwait, 2'b10);
    chk("rd_acc_iload", iload[0], 32'hDEADBEEF);
    chk("rd_acc_addr", ramaddr, 32'h40);
    tick(); quiet();
    settle();
    chk("rd_after_iwait", iwait, 2'b11);
    chk("rd_after_iload", iload[0], 0);
    tick();

    // data write beats instruction fetch
    iREN = 2'b01; dWEN = 2'b01;
    daddr[0] = 32'h80; dstore[0] = 32'h1234;
    settle(); tick();
    settle();
    chk("dp_wen", ramWEN, 1);
    chk("dp_ren", ramREN, 0);
    chk("dp_addr", ramaddr, 32'h80);
    chk("dp_store", ramstore, 32'h1234);
    chk("dp_dwait", dwait, 2'b10);
    chk("dp_iwait", iwait, 2'b11);
    tick(); dWEN = '0;
    settle(); chk("dp_idle_iwait", iwait, 2'b11);
    tick();
    settle(); chk("dp_fetch_iwait", iwait, 2'b10);
    tick(); quiet();

    // round robin from a fresh pointer
    RST = 1; tick(); tick(); RST = 0;
    dREN = 2'b11; ramstate = ACCESS;
    rr_exp = '{2'b11, 2'b10, 2'b11, 2'b01,
               2'b11, 2'b10, 2'b11, 2'b01};
    for (int i = 0; i < 8; i++) begin
      settle(); chk("rr_dwait", dwait, rr_exp[i]); tick();
    end
    quiet(); settle(); tick();

    // abort leaves the pointer at core1
    dREN = 2'b01; settle(); tick(); settle(); tick();
    dREN = 2'b10; ramstate = BUSY;
    settle(); tick();
    settle(); chk("ab_ren", ramREN, 1); tick();
    dREN = 2'b00;
    settle();
    chk("ab_drop_ren", ramREN, 0);
    chk("ab_drop_dwait", dwait, 2'b11);
    tick();
    settle(); chk("ab_idle_ren", ramREN, 0); tick();
    dREN = 2'b11; ramstate = ACCESS;
    settle(); tick();
    settle(); chk("ab_next_dwait", dwait, 2'b01);
    tick(); quiet(); settle(); tick();

    // ERROR is not terminal
    dREN = 2'b01; ramstate = ERROR; daddr[0] = 32'h100;
    settle(); tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("err_dwait", dwait, 2'b11);
      chk("err_ren", ramREN, 1);
      tick();
    end
    ramstate = ACCESS; ramload = 32'hCAFE0001;
    settle();
    chk("err_done_dwait", dwait, 2'b10);
    chk("err_done_dload", dload[0], 32'hCAFE0001);
    tick(); quiet(); settle(); tick();

    // reset while transferring
    iREN = 2'b01; ramstate = BUSY;
    settle(); tick();
    settle(); chk("rx_ren", ramREN, 1);
    RST = 1; tick(); RST = 0;
    settle(); chk("rx_after_ren", ramREN, 0);
    chk("rx_after_iwait", iwait, 2'b11);
    tick(); quiet(); settle(); tick();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      RST = ($urandom_range(0, 63) == 0);
      for (int c = 0; c < CPUS; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          iREN[c] = $urandom_range(0, 1) == 1;
          dREN[c] = $urandom_range(0, 2) == 0;
          dWEN[c] = $urandom_range(0, 2) == 0;
        end
        iaddr[c]  = $urandom;
        daddr[c]  = $urandom;
        dstore[c] = $urandom;
      end
      ramstate = ramstate_t'($urandom_range(0, 3));
      ramload  = $urandom;
      settle(); tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
